// File: rtl/vector_execution_pipe_pkg.sv
// Shared opcodes, default geometry and helpers for the vector execution pipe.
// SATURATE_EN (optional define) switches ADD/SUB from wrapping to clamping.
package vector_exec_pkg;

  localparam int DEF_BITS_OPCODE = 4;
  localparam int DEF_BITS_DATA   = 8;
  localparam int DEF_LANES       = 8;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_MIN   = 4'd8,
    OP_MAX   = 4'd9,
    OP_PASSB = 4'd10
  } op_e;

  // Width of the shift-amount field taken from the low bits of operand B.
  function automatic int shamt_bits(input int bits_data);
    int w;
    w = $clog2(bits_data);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vector_execution_pipe_if.sv
// Operand/result handshake bundle for the vector execution pipe.
// master = operand-fetch / writeback side, slave = the pipe.
interface vector_execution_pipe_if
  import vector_exec_pkg::*;
#(
  parameter int BITS_OPCODE = DEF_BITS_OPCODE,
  parameter int BITS_DATA   = DEF_BITS_DATA,
  parameter int LANES       = DEF_LANES
);

  logic                         inValid;
  logic                         inReady;
  logic [BITS_OPCODE-1:0]       opCode;
  logic [LANES-1:0]             laneMask;
  logic [LANES*BITS_DATA-1:0]   arrayA;
  logic [LANES*BITS_DATA-1:0]   arrayB;
  logic                         outValid;
  logic                         outReady;
  logic [LANES*BITS_DATA-1:0]   executionResult;
  logic [LANES-1:0]             laneCarry;
  logic [LANES-1:0]             laneZero;
  logic                         anyZero;

  modport master (
    output inValid, opCode, laneMask, arrayA, arrayB, outReady,
    input  inReady, outValid, executionResult, laneCarry, laneZero, anyZero
  );

  modport slave (
    input  inValid, opCode, laneMask, arrayA, arrayB, outReady,
    output inReady, outValid, executionResult, laneCarry, laneZero, anyZero
  );

endinterface

// File: rtl/vector_execution_pipe_lane_alu.sv
// Combinational single-lane ALU; a masked-out lane passes operand a through.
// SATURATE_EN selects clamping ADD/SUB, otherwise they wrap.
module vector_lane_alu
  import vector_exec_pkg::*;
#(
  parameter int BITS_OPCODE = DEF_BITS_OPCODE,
  parameter int BITS_DATA   = DEF_BITS_DATA
) (
  input  logic [BITS_OPCODE-1:0] opCode,
  input  logic [BITS_DATA-1:0]   a,
  input  logic [BITS_DATA-1:0]   b,
  input  logic                   mask,
  output logic [BITS_DATA-1:0]   result,
  output logic                   carry,
  output logic                   zero
);

  localparam int SHW = shamt_bits(BITS_DATA);

  logic [BITS_DATA:0]   sum;
  logic [BITS_DATA:0]   diff;
  logic [SHW-1:0]       shamt;
  logic [BITS_DATA-1:0] op_res;
  logic                 op_carry;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    case (opCode)
      BITS_OPCODE'(OP_ADD): begin
        op_carry = sum[BITS_DATA];
`ifdef SATURATE_EN
        op_res   = sum[BITS_DATA] ? '1 : sum[BITS_DATA-1:0];
`else
        op_res   = sum[BITS_DATA-1:0];
`endif
      end
      BITS_OPCODE'(OP_SUB): begin
        // bit BITS_DATA of the extended difference is the borrow
        op_carry = diff[BITS_DATA];
`ifdef SATURATE_EN
        op_res   = diff[BITS_DATA] ? '0 : diff[BITS_DATA-1:0];
`else
        op_res   = diff[BITS_DATA-1:0];
`endif
      end
      BITS_OPCODE'(OP_AND):   op_res = a & b;
      BITS_OPCODE'(OP_OR):    op_res = a | b;
      BITS_OPCODE'(OP_XOR):   op_res = a ^ b;
      BITS_OPCODE'(OP_NOT):   op_res = ~a;
      BITS_OPCODE'(OP_SHL):   op_res = a << shamt;
      BITS_OPCODE'(OP_SHR):   op_res = a >> shamt;
      BITS_OPCODE'(OP_MIN):   op_res = (a < b) ? a : b;
      BITS_OPCODE'(OP_MAX):   op_res = (a > b) ? a : b;
      BITS_OPCODE'(OP_PASSB): op_res = b;
      default: begin
        op_res   = '0;
        op_carry = 1'b0;
      end
    endcase
  end

  assign result = mask ? op_res : a;
  assign carry  = mask & op_carry;
  assign zero   = (result == '0);

endmodule

// File: rtl/vector_execution_pipe.sv
// Two-stage SIMD execution pipe: S1 holds operands, S2 holds lane results/flags.
// SATURATE_EN (optional define, consumed by vector_lane_alu) clamps ADD/SUB.
module vector_execution_pipe
  import vector_exec_pkg::*;
#(
  parameter int BITS_OPCODE = DEF_BITS_OPCODE,
  parameter int BITS_DATA   = DEF_BITS_DATA,
  parameter int LANES       = DEF_LANES
) (
  input logic                    clk,
  input logic                    rstN,
  vector_execution_pipe_if.slave bus
);

  localparam int W = LANES * BITS_DATA;

  logic                   ready_s1;
  logic                   ready_s2;

  logic                   s1_valid;
  logic [BITS_OPCODE-1:0] s1_op;
  logic [LANES-1:0]       s1_mask;
  logic [W-1:0]           s1_a;
  logic [W-1:0]           s1_b;

  logic                   s2_valid;
  logic [W-1:0]           s2_res;
  logic [LANES-1:0]       s2_carry;
  logic [LANES-1:0]       s2_zero;
  logic                   s2_any;

  logic [W-1:0]           alu_res;
  logic [LANES-1:0]       alu_carry;
  logic [LANES-1:0]       alu_zero;
  logic                   alu_any;

  // Combinational ready chain lets S2 drain and S1 refill in the same cycle.
  assign ready_s2    = !s2_valid || bus.outReady;
  assign ready_s1    = !s1_valid || ready_s2;
  assign bus.inReady = ready_s1;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_mask  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (ready_s1) begin
      s1_valid <= bus.inValid;
      if (bus.inValid) begin
        s1_op   <= bus.opCode;
        s1_mask <= bus.laneMask;
        s1_a    <= bus.arrayA;
        s1_b    <= bus.arrayB;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vector_lane_alu #(
      .BITS_OPCODE (BITS_OPCODE),
      .BITS_DATA   (BITS_DATA)
    ) u_alu (
      .opCode (s1_op),
      .a      (s1_a[i*BITS_DATA +: BITS_DATA]),
      .b      (s1_b[i*BITS_DATA +: BITS_DATA]),
      .mask   (s1_mask[i]),
      .result (alu_res[i*BITS_DATA +: BITS_DATA]),
      .carry  (alu_carry[i]),
      .zero   (alu_zero[i])
    );
  end

  // Masked-out lanes still report laneZero but never raise anyZero.
  assign alu_any = |(alu_zero & s1_mask);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_carry <= '0;
      s2_zero  <= '0;
      s2_any   <= 1'b0;
    end else if (ready_s2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res   <= alu_res;
        s2_carry <= alu_carry;
        s2_zero  <= alu_zero;
        s2_any   <= alu_any;
      end
    end
  end

  assign bus.outValid        = s2_valid;
  assign bus.executionResult = s2_res;
  assign bus.laneCarry       = s2_carry;
  assign bus.laneZero        = s2_zero;
  assign bus.anyZero         = s2_any;

endmodule

// File: tb/tb_vector_execution_pipe.sv
// Directed self-checking bench for vector_execution_pipe (8 lanes x 8 bits).
// Honours SATURATE_EN for the clamped ADD/SUB expectations.
module tb_vector_execution_pipe;

  localparam int BO = 4;
  localparam int BD = 8;
  localparam int LN = 8;
  localparam int W  = LN * BD;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  vector_execution_pipe_if #(.BITS_OPCODE(BO), .BITS_DATA(BD), .LANES(LN)) bus ();

  vector_execution_pipe #(.BITS_OPCODE(BO), .BITS_DATA(BD), .LANES(LN)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  typedef struct packed {
    logic [W-1:0]  res;
    logic [LN-1:0] carry;
    logic [LN-1:0] zero;
    logic          any;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_in     = 0;
  int    n_out    = 0;
  int    cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Integer reference model of one beat.
  function automatic beat_t model(input logic [3:0] op, input logic [LN-1:0] m,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
    beat_t e;
    int x, y, r, sh;
    logic c;
    e = '0;
    for (int i = 0; i < LN; i++) begin
      x  = int'(a[i*BD +: BD]);
      y  = int'(b[i*BD +: BD]);
      sh = y % 8;
      c  = 1'b0;
      r  = 0;
      case (op)
        4'd0: begin
          r = x + y;
          c = (r > 255);
`ifdef SATURATE_EN
          if (c) r = 255;
`endif
        end
        4'd1: begin
          r = x - y;
          c = (x < y);
`ifdef SATURATE_EN
          if (c) r = 0;
`endif
        end
        4'd2:    r = x & y;
        4'd3:    r = x | y;
        4'd4:    r = x ^ y;
        4'd5:    r = 255 - x;
        4'd6:    r = x * (1 << sh);
        4'd7:    r = x / (1 << sh);
        4'd8:    r = (x < y) ? x : y;
        4'd9:    r = (x > y) ? x : y;
        4'd10:   r = y;
        default: r = 0;
      endcase
      if (!m[i]) begin
        r = x;
        c = 1'b0;
      end
      e.res[i*BD +: BD] = r[7:0];
      e.carry[i]        = c;
      e.zero[i]         = (r[7:0] == 8'h00);
      if (m[i] && e.zero[i]) e.any = 1'b1;
    end
    return e;
  endfunction

  // Scoreboard: push on accepted beats, check on output handshakes and stalls.
  always @(negedge clk) begin
    beat_t e;
    if (rstN) begin
      if (bus.outValid) begin
        if (exp_q.size() == 0) begin
          chk_val("extra_beat", bus.outValid, 0);
        end else begin
          e = exp_q[0];
          if (bus.outReady) begin
            chk_val("sb_result", bus.executionResult, e.res);
            chk_val("sb_carry",  bus.laneCarry,       e.carry);
            chk_val("sb_zero",   bus.laneZero,        e.zero);
            chk_val("sb_any",    bus.anyZero,         e.any);
            void'(exp_q.pop_front());
            n_out++;
          end else begin
            chk_val("stall_hold", bus.executionResult, e.res);
          end
        end
      end
      if (bus.inValid && bus.inReady) begin
        exp_q.push_back(model(bus.opCode, bus.laneMask, bus.arrayA, bus.arrayB));
        n_in++;
      end
    end
  end

  // Present a beat and return 1 time unit after the edge that accepts it.
  task automatic drive(input logic [3:0] op, input logic [LN-1:0] m,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int cnt = 0;
    bus.opCode   = op;
    bus.laneMask = m;
    bus.arrayA   = a;
    bus.arrayB   = b;
    bus.inValid  = 1'b1;
    @(negedge clk);
    while (!bus.inReady && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) chk_val("accept_timeout", bus.inReady, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic one_shot(input string tag, input logic [3:0] op, input logic [LN-1:0] m,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] x_res, input logic [LN-1:0] x_c,
                          input logic [LN-1:0] x_z, input logic x_any);
    int cnt = 0;
    bus.outReady = 1'b1;
    drive(op, m, a, b);
    bus.inValid = 1'b0;
    @(negedge clk);
    while (!bus.outValid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.outValid) begin
      chk_val({tag, "_timeout"}, bus.outValid, 1);
    end else begin
      chk_val({tag, "_res"},   bus.executionResult, x_res);
      chk_val({tag, "_carry"}, bus.laneCarry,       x_c);
      chk_val({tag, "_zero"},  bus.laneZero,        x_z);
      chk_val({tag, "_any"},   bus.anyZero,         x_any);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rstN         = 1'b1;
    bus.inValid  = 1'b0;
    bus.opCode   = '0;
    bus.laneMask = '0;
    bus.arrayA   = '0;
    bus.arrayB   = '0;
    bus.outReady = 1'b1;
    #1 rstN = 1'b0;
    #1;
    chk_val("rst_outvalid", bus.outValid,        0);
    chk_val("rst_result",   bus.executionResult, 0);
    chk_val("rst_carry",    bus.laneCarry,       0);
    chk_val("rst_zero",     bus.laneZero,        0);
    chk_val("rst_any",      bus.anyZero,         0);
    chk_val("rst_inready",  bus.inReady,         1);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

`ifdef SATURATE_EN
    one_shot("add_ovf", 4'd0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101,
             64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'h00, 1'b0);
    one_shot("sub_brw", 4'd1, 8'h01, 64'h1111_1111_1111_1105, 64'h0000_0000_0000_0007,
             64'h1111_1111_1111_1100, 8'h01, 8'h01, 1'b1);
`else
    one_shot("add_ovf", 4'd0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101,
             64'h0000_0000_0000_0000, 8'hFF, 8'hFF, 1'b1);
    one_shot("sub_brw", 4'd1, 8'h01, 64'h1111_1111_1111_1105, 64'h0000_0000_0000_0007,
             64'h1111_1111_1111_11FE, 8'h01, 8'h00, 1'b0);
`endif
    one_shot("shl9", 4'd6, 8'hFF, 64'h8181_8181_8181_8181, 64'h0909_0909_0909_0909,
             64'h0202_0202_0202_0202, 8'h00, 8'h00, 1'b0);
    one_shot("shr9", 4'd7, 8'hFF, 64'h8181_8181_8181_8181, 64'h0909_0909_0909_0909,
             64'h4040_4040_4040_4040, 8'h00, 8'h00, 1'b0);
    one_shot("op13", 4'd13, 8'hF0, 64'h0102_0304_0506_0708, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h0000_0000_0506_0708, 8'h00, 8'hF0, 1'b1);

    // Back-to-back stream of every opcode: must accept one beat per cycle.
    t0 = cyc;
    for (int op = 0; op < 16; op++)
      drive(4'(op), 8'hFF, {$urandom, $urandom}, {$urandom, $urandom});
    for (int op = 0; op < 16; op++)
      drive(4'(op), 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    chk_val("stream_rate", cyc - t0, 32);
    bus.inValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two beats fill the pipe, third must wait.
    bus.outReady = 1'b0;
    drive(4'd0, 8'hFF, 64'h0102_0304_0506_0708, 64'h1010_1010_1010_1010);
    drive(4'd4, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    bus.opCode   = 4'd9;
    bus.laneMask = 8'hFF;
    bus.arrayA   = 64'h00FF_00FF_1234_5678;
    bus.arrayB   = 64'h0F0F_F0F0_4321_8765;
    bus.inValid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_val("stall_inready", bus.inReady,  0);
      chk_val("stall_outvalid", bus.outValid, 1);
    end
    @(posedge clk);
    #1;
    bus.outReady = 1'b1;
    drive(4'd9, 8'hFF, 64'h00FF_00FF_1234_5678, 64'h0F0F_F0F0_4321_8765);
    drive(4'd8, 8'hFF, 64'h00FF_00FF_1234_5678, 64'h0F0F_F0F0_4321_8765);
    bus.inValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_val("stall_count", n_out, n_in);

    // Asynchronous reset with both stages full drops the in-flight beats.
    bus.outReady = 1'b0;
    drive(4'd0, 8'hFF, 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101);
    drive(4'd3, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0);
    bus.inValid = 1'b0;
    #3 rstN = 1'b0;
    #1;
    chk_val("arst_outvalid", bus.outValid,        0);
    chk_val("arst_result",   bus.executionResult, 0);
    chk_val("arst_carry",    bus.laneCarry,       0);
    chk_val("arst_zero",     bus.laneZero,        0);
    chk_val("arst_any",      bus.anyZero,         0);
    chk_val("arst_inready",  bus.inReady,         1);
    exp_q.delete();
    n_in = n_out;
    @(posedge clk);
    #3 rstN = 1'b1;
    bus.outReady = 1'b1;
    @(posedge clk);
    #1;
    drive(4'd10, 8'hFF, 64'h0, 64'hDEAD_BEEF_0BAD_F00D);
    bus.inValid = 1'b0;
    @(negedge clk);
    chk_val("lat_pre", bus.outValid, 0);
    @(posedge clk);
    #1;
    chk_val("lat_post", bus.outValid, 1);
    repeat (3) @(posedge clk);
    #1;

    chk_val("sb_empty", exp_q.size(), 0);
    chk_val("in_out",   n_out, n_in);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_execution_pipe.md
# vector_execution_pipe

Parametrised, pipelined SIMD execution unit. It applies one opcode to LANES independent BITS_DATA-wide lanes of two packed operand arrays, with a per-lane write mask. A valid/ready handshake sits on each side. It is the next generation of the combinational 8×8-bit execution stage: the datapath sits between the operand-fetch and writeback stages, and the pipe absorbs backpressure from writeback.

## Interface
- BITS_OPCODE, 4, opcode width
- BITS_DATA, 8, lane width (≥2)
- LANES, 8, lane count (≥1); array width = LANES*BITS_DATA
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous, active-low reset
- inValid  input  1  operand beat valid
- inReady  output  1  pipe accepts beat this cycle
- opCode  input  BITS_OPCODE  lane operation
- laneMask  input  LANES  1 = lane computes; 0 = lane passes arrayA through
- arrayA  input  LANES*BITS_DATA  operand A; lane i = bits [i*BITS_DATA +: BITS_DATA]
- arrayB  input  LANES*BITS_DATA  operand B, same packing
- outValid  output  1  result beat valid
- outReady  input  1  downstream accepts result
- executionResult  output  LANES*BITS_DATA  packed lane results
- laneCarry  output  LANES  per-lane carry/borrow out (ADD/SUB only, else 0)
- laneZero  output  LANES  per-lane result == 0
- anyZero  output  1  OR of laneZero over masked-in lanes

## Operation
- Opcodes, unsigned lanes:
  - 0 ADD
  - 1 SUB (A−B; carry = borrow)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL A by B[log2(BITS_DATA)-1:0]
  - 7 SHR logical, same shift amount
  - 8 MIN
  - 9 MAX
  - 10 PASS B
  - 11–15 result 0, carry 0
- Arithmetic is computed at BITS_DATA+1 bits. The result is the low BITS_DATA bits; the carry is bit BITS_DATA. No cross-lane carry.
- A masked-out lane outputs arrayA unchanged, with laneCarry=0. Its laneZero still reflects that output, but it is excluded from anyZero.
- Stage S1 registers opCode, laneMask and the operands on acceptance (inValid && inReady).
- Stage S2 registers the lane results and flags computed from S1.
- Each stage holds valid_k:
  - ready_S2 = !valid_S2 || outReady
  - ready_S1 = !valid_S1 || ready_S2
  - inReady = ready_S1
- The ready chain is combinational. Data registers load only when their stage advances; while stalled they hold their values.

## Timing
- Latency: 2 cycles from accepted input to outValid when unstalled. Throughput: 1 beat/cycle.
- Reset (rstN low, asynchronous): valid_S1 = valid_S2 = 0, so outValid = 0. executionResult, laneCarry, laneZero and anyZero are 0. inReady = 1 once rstN deasserts, and also combinationally during reset.
- Reset mid-operation: in-flight beats are dropped, not replayed.
- Stall (outReady=0 while outValid=1): outputs stay stable.
  - S1 still accepts one beat if empty. After that, inReady=0.
  - Resume: the held beat leaves first, then S1's beat; order is preserved.
- Simultaneous S2 drain and S1 fill in the same cycle is a legal full-rate case; no bubble is inserted.
- outValid never drops without a handshake, and data never changes while outValid && !outReady.

## Configuration
- SATURATE_EN defined: ADD clamps to 2^BITS_DATA−1 on overflow, and SUB clamps to 0 on borrow. laneCarry still reports the raw carry/borrow.
- Undefined: ADD/SUB wrap modulo 2^BITS_DATA.
- All other opcodes are unaffected.

## Structure
- Package vector_exec_pkg holds:
  - opcode localparams/enum (OP_ADD … OP_PASSB)
  - default BITS_OPCODE/BITS_DATA/LANES
  - a shift-amount width function
- Sub-module vector_lane_alu: purely combinational single-lane ALU (opCode, a, b, mask → result, carry, zero), instantiated LANES times by generate.
- The pipeline registers and handshake live in the top module only.

## Test plan
- LANES=8, BITS_DATA=8, ADD with A=0xFF in every lane, B=0x01 in every lane, mask=0xFF, outReady=1. Response after 2 cycles: result 0x00 in every lane, laneCarry=0xFF, laneZero=0xFF, anyZero=1. With SATURATE_EN: 0xFF in every lane, laneZero=0x00.
- SUB, A lane0=0x05, B lane0=0x07, mask=0x01, other A lanes=0x11. Response: lane0=0xFE (SATURATE_EN: 0x00) with laneCarry[0]=1; lanes 1–7 = 0x11, carry 0; anyZero=0 (1 with SATURATE_EN).
- Streaming opcodes 0–15 back-to-back with random operands, outReady=1. Response: one result per cycle, in order, matching the reference model, and opcodes 11–15 give zero.
- Hold outReady=0 for 5 cycles during a stream. Response: outputs stable, inReady falls after exactly 2 beats are held, no beat lost or duplicated on release.
- Assert rstN low asynchronously (between clock edges) with both stages full. Response: outValid=0 and outputs 0 immediately; after release, the first result appears 2 cycles after the next accepted beat.
- SHL/SHR with B lane=9 at BITS_DATA=8. Response: shift by 1, since only the low 3 bits are used.
